// File: rtl/phi0_halt_ctrl.sv
// phi0 clock divider and HALT request generator for the 6502C phi1/phi2 stage.
// Debounced halt switch and single-step button; HALT only moves on phi0 rising edges.
module phi0_halt_ctrl #(
  parameter int DIV_HALF  = 4,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input  logic             USER_CLK,
  input  logic             RST_N,
  input  logic             SW_HALT,
  input  logic             BTN_STEP,
  output logic             phi0_out,
  output logic             HALT,
  output logic             halted,
  output logic             stepping,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DW  = (DIV_HALF  > 2) ? $clog2(DIV_HALF)  : 1;
  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV_HALF - 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP_RUN = 2'd2
  } state_e;

  // Bit 0 = halt switch, bit 1 = step button.
  logic [1:0]     raw_s;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     db_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic           step_prev_q;
  logic           step_evt_s;
  logic           sw_db_s;

  logic [DW-1:0]  div_cnt_q;
  logic           phi0_q;
  logic           rise_evt_s;

  state_e         state_q, state_d;
  logic           halt_q, halt_d;
  logic           halted_q, halted_d;
  logic           stepping_q, stepping_d;
  logic           pending_q, pending_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  assign raw_s = {BTN_STEP, SW_HALT};

  // Two-flop synchronizers for both raw inputs.
  always_ff @(posedge USER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: a level is accepted only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge USER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      db_q        <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      step_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + {{(DBW-1){1'b0}}, 1'b1};
        end
      end
      step_prev_q <= db_q[1];
    end
  end

  assign sw_db_s    = db_q[0];
  assign step_evt_s = db_q[1] & ~step_prev_q;

  // Free-running phi0 divider; keeps toggling while halted.
  always_ff @(posedge USER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      phi0_q    <= 1'b0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
      phi0_q    <= ~phi0_q;
    end else begin
      div_cnt_q <= div_cnt_q + {{(DW-1){1'b0}}, 1'b1};
      phi0_q    <= phi0_q;
    end
  end

  assign rise_evt_s = (div_cnt_q == DIV_LAST) && !phi0_q;

  // Halt FSM: all state and output changes are gated by rise_evt.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cyc_cnt_d  = cyc_cnt_q;

    if (rise_evt_s) begin
      case (state_q)
        ST_HALTED: begin
          if (!sw_db_s) begin
            state_d = ST_RUN;
          end else if (pending_q) begin
            state_d = ST_STEP_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_RUN: begin
          if (sw_db_s) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STEP_RUN: state_d = ST_HALTED;
        default:     state_d = ST_HALTED;
      endcase
    end else begin
      state_d = state_q;
    end

    halt_d     = (state_d == ST_HALTED);
    halted_d   = (state_d == ST_HALTED);
    stepping_d = (state_d == ST_STEP_RUN);

    // Leaving HALTED either consumes the pending step or abandons it for RUN.
    if (rise_evt_s && (state_q == ST_HALTED) && (state_d != ST_HALTED)) begin
      pending_d = 1'b0;
    end else if (step_evt_s && (state_q == ST_HALTED)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (rise_evt_s && !halt_d) begin
      cyc_cnt_d = cyc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge USER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_HALTED;
      halt_q     <= 1'b1;
      halted_q   <= 1'b1;
      stepping_q <= 1'b0;
      pending_q  <= 1'b0;
      cyc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_d;
      halted_q   <= halted_d;
      stepping_q <= stepping_d;
      pending_q  <= pending_d;
      cyc_cnt_q  <= cyc_cnt_d;
    end
  end

  assign phi0_out  = phi0_q;
  assign HALT      = halt_q;
  assign halted    = halted_q;
  assign stepping  = stepping_q;
  assign cycle_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_phi0_halt_ctrl.sv
// Directed bench for phi0_halt_ctrl; cycle numbers count USER_CLK edges after RST_N release.
module tb_phi0_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_halt;
  logic        btn_step;
  logic        phi0;
  logic        halt;
  logic        halted;
  logic        stepping;
  logic [15:0] cnt;

  logic        phi0_4, halt_4, halted_4, stepping_4;
  logic [3:0]  cnt_4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  phi0_halt_ctrl #(.DIV_HALF(4), .DB_CYCLES(16), .CNT_W(16)) u_dut (
    .USER_CLK (clk),
    .RST_N    (rst_n),
    .SW_HALT  (sw_halt),
    .BTN_STEP (btn_step),
    .phi0_out (phi0),
    .HALT     (halt),
    .halted   (halted),
    .stepping (stepping),
    .cycle_cnt(cnt)
  );

  // Narrow counter instance, always running, to exercise wrap-around.
  phi0_halt_ctrl #(.DIV_HALF(4), .DB_CYCLES(16), .CNT_W(4)) u_dut4 (
    .USER_CLK (clk),
    .RST_N    (rst_n),
    .SW_HALT  (1'b0),
    .BTN_STEP (1'b0),
    .phi0_out (phi0_4),
    .HALT     (halt_4),
    .halted   (halted_4),
    .stepping (stepping_4),
    .cycle_cnt(cnt_4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic reset_release();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sw_halt = 1'b0; btn_step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phi0", phi0, 0);
    chk("rst_halt", halt, 1);
    chk("rst_halted", halted, 1);
    chk("rst_stepping", stepping, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_cnt4", cnt_4, 0);
    reset_release();

    // First rise at cycle 4 releases HALT
    goto(3);   chk("pre_rise_phi0", phi0, 0); chk("pre_rise_halt", halt, 1);
    goto(4);   chk("rise1_phi0", phi0, 1); chk("rise1_halt", halt, 0);
               chk("rise1_halted", halted, 0); chk("rise1_cnt", cnt, 1);
    goto(8);   chk("fall1_phi0", phi0, 0);
    goto(11);  chk("low_phi0", phi0, 0);
    goto(12);  chk("rise2_phi0", phi0, 1); chk("rise2_cnt", cnt, 2);

    // 10-cycle halt glitch must be ignored
    sw_halt = 1'b1;
    goto(22);  sw_halt = 1'b0;
    goto(44);  chk("glitch_halt", halt, 0); chk("glitch_cnt", cnt, 6);

    // Held halt switch: debounced at 62, HALT rises at 68
    sw_halt = 1'b1;
    goto(60);  chk("hold_cnt60", cnt, 8); chk("hold_halt60", halt, 0);
    goto(67);  chk("hold_halt67", halt, 0);
    goto(68);  chk("halt_rise", halt, 1); chk("halt_halted", halted, 1); chk("halt_cnt", cnt, 8);

    // Long step press: one 8-cycle step at 92..99
    goto(70);  btn_step = 1'b1;
    goto(91);  chk("step_pre", halt, 1);
    goto(92);  chk("step_halt", halt, 0); chk("step_stepping", stepping, 1);
               chk("step_halted", halted, 0); chk("step_cnt", cnt, 9);
    goto(99);  chk("step_end_halt", halt, 0); chk("step_end_stepping", stepping, 1);
    goto(100); chk("step_done_halt", halt, 1); chk("step_done_stepping", stepping, 0);
               chk("step_done_halted", halted, 1); chk("step_done_cnt", cnt, 9);
    goto(108); chk("long_press_halt", halt, 1);

    // 4-bit counter wraps 15 -> 0
    goto(116); chk("wrap_cnt4_116", cnt_4, 15);
    goto(123); chk("wrap_cnt4_123", cnt_4, 15);
    goto(124); chk("wrap_cnt4_124", cnt_4, 0);
    goto(132); chk("wrap_cnt4_132", cnt_4, 1); chk("long_press_cnt", cnt, 9);
    goto(170); btn_step = 1'b0;
    goto(190); chk("after_long_halt", halt, 1); chk("after_long_cnt", cnt, 9);

    // Three separate presses while halted
    goto(196); btn_step = 1'b1;
    goto(222); chk("p1_halt", halt, 0); chk("p1_stepping", stepping, 1); chk("p1_cnt", cnt, 10);
    goto(226); btn_step = 1'b0;
    goto(240); chk("p1_after_halt", halt, 1); chk("p1_after_cnt", cnt, 10);
    goto(252); btn_step = 1'b1;
    goto(282); btn_step = 1'b0;
    goto(296); chk("p2_after_halt", halt, 1); chk("p2_after_cnt", cnt, 11);
    goto(308); btn_step = 1'b1;
    goto(338); btn_step = 1'b0;
    goto(350); chk("p3_after_halt", halt, 1); chk("p3_after_cnt", cnt, 12);

    // Resume running, press step while running: discarded
    sw_halt = 1'b0;
    goto(371); chk("resume_pre", halt, 1);
    goto(372); chk("resume_halt", halt, 0); chk("resume_halted", halted, 0); chk("resume_cnt", cnt, 13);
    goto(380); btn_step = 1'b1;
    goto(410); btn_step = 1'b0;
    goto(420); chk("run_btn_halt", halt, 0); chk("run_btn_stepping", stepping, 0); chk("run_btn_cnt", cnt, 19);
    sw_halt = 1'b1;
    goto(444); chk("rehalt_halt", halt, 1); chk("rehalt_cnt", cnt, 21);
    goto(452); chk("no_stale_halt", halt, 1); chk("no_stale_stepping", stepping, 0); chk("no_stale_cnt", cnt, 21);

    // Reset in the middle of a step
    goto(460); btn_step = 1'b1;
    goto(484); chk("mid_step_stepping", stepping, 1); chk("mid_step_halt", halt, 0); chk("mid_step_cnt", cnt, 22);
    goto(486);
    rst_n = 1'b0;
    #1;
    chk("arst_halt", halt, 1); chk("arst_stepping", stepping, 0); chk("arst_halted", halted, 1);
    chk("arst_phi0", phi0, 0); chk("arst_cnt", cnt, 0);
    btn_step = 1'b0;
    reset_release();
    goto(40);  chk("post_rst_halted40", halted, 1); chk("post_rst_halt40", halt, 1);
    goto(60);  chk("post_rst_halted60", halted, 1); chk("post_rst_halt60", halt, 1);
               chk("post_rst_stepping60", stepping, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
